// File: rtl/cla_subtractor_seq.sv
// Multi-cycle borrow-lookahead subtractor: DIFF = A - B - BIN over W bits,
// resolving one SLICE-bit lookahead slice per clock, LSB slice first.
module cla_subtractor_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int unsigned N    = W / SLICE;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  generate
    if ((W % SLICE) != 0) begin : g_bad_slice
      $error("cla_subtractor_seq: W must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_borrow;
  logic [IDXW-1:0]  r_idx;
  logic [W-1:0]     r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_a_s;
  logic [SLICE-1:0] w_b_s;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_br;
  logic [SLICE-1:0] w_d_s;
  logic [W-1:0]     w_diff_next;
  logic             w_ovf_next;

  assign w_accept = start & (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

  // Borrow-lookahead over the current slice; merges its difference bits into the result.
  always_comb begin
    w_a_s = r_a[r_idx*SLICE +: SLICE];
    w_b_s = r_b[r_idx*SLICE +: SLICE];
    w_g   = ~w_a_s & w_b_s;
    w_p   = ~(w_a_s ^ w_b_s);
    w_br  = '0;
    w_d_s = '0;
    w_br[0] = r_borrow;
    for (int unsigned k = 0; k < SLICE; k++) begin
      w_br[k+1] = w_g[k] | (w_p[k] & w_br[k]);
      w_d_s[k]  = w_a_s[k] ^ w_b_s[k] ^ w_br[k];
    end
    w_diff_next = r_diff;
    w_diff_next[r_idx*SLICE +: SLICE] = w_d_s;
    // Signed overflow uses the MSB of the result being completed this cycle.
    w_ovf_next = (r_a[W-1] != r_b[W-1]) && (w_diff_next[W-1] != r_a[W-1]);
  end

  // Next-state logic for the IDLE/RUN/DONE handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_idx == LAST_IDX) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture, per-slice result accumulation and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_idx    <= '0;
    end else if (r_state == S_RUN) begin
      r_diff   <= w_diff_next;
      r_borrow <= w_br[SLICE];
      r_idx    <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_bout <= w_br[SLICE];
        r_ovf  <= w_ovf_next;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
